// File: rtl/collision_event_ctrl_pkg.sv
//==============================================================================
// Module      : collision_pkg
// Description : Shared types and constants for the collision event controller
//               (player life-state encoding, one-hot pop credit codes).
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

package collision_pkg;

    typedef enum logic [1:0] {
        P_ALIVE  = 2'd0,
        P_INVULN = 2'd1,
        P_DEAD   = 2'd2
    } player_state_t;

    localparam logic [1:0] CREDIT_P1 = 2'b01;
    localparam logic [1:0] CREDIT_P2 = 2'b10;

endpackage

`default_nettype wire

// File: rtl/collision_event_ctrl_if.sv
//==============================================================================
// Module      : collision_event_ctrl_if
// Description : Bundle of per-pixel collision inputs, frame/game strobes and
//               game-event outputs of the collision event controller.
//               master = collision detector / video side, slave = controller.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

interface collision_event_ctrl_if #(
    parameter int LIVES_W = 3
) ();

    logic               startOfFrame;
    logic               newGame;
    logic               twoPlayer;
    logic               bubbleHitChar_1;
    logic               bubbleHitChar_2;
    logic               arrow_1_HitBubble;
    logic               arrow_2_HitBubble;
    logic               lifeHitChar;

    logic               popBubble;
    logic [1:0]         popCredit;
    logic               arrowClear_1;
    logic               arrowClear_2;
    logic               charHit_1;
    logic               charHit_2;
    logic               lifeGain_1;
    logic               lifeGain_2;
    logic               invuln_1;
    logic               invuln_2;
    logic [LIVES_W-1:0] lives_1;
    logic [LIVES_W-1:0] lives_2;
    logic               gameOver;

    modport master (
        output startOfFrame, newGame, twoPlayer,
        output bubbleHitChar_1, bubbleHitChar_2,
        output arrow_1_HitBubble, arrow_2_HitBubble, lifeHitChar,
        input  popBubble, popCredit, arrowClear_1, arrowClear_2,
        input  charHit_1, charHit_2, lifeGain_1, lifeGain_2,
        input  invuln_1, invuln_2, lives_1, lives_2, gameOver
    );

    modport slave (
        input  startOfFrame, newGame, twoPlayer,
        input  bubbleHitChar_1, bubbleHitChar_2,
        input  arrow_1_HitBubble, arrow_2_HitBubble, lifeHitChar,
        output popBubble, popCredit, arrowClear_1, arrowClear_2,
        output charHit_1, charHit_2, lifeGain_1, lifeGain_2,
        output invuln_1, invuln_2, lives_1, lives_2, gameOver
    );

endinterface

`default_nettype wire

// File: rtl/collision_event_ctrl_player.sv
//==============================================================================
// Module      : player_life_fsm
// Description : Per-player life sequencer: ALIVE / INVULN / DEAD state, lives
//               counter and invulnerability frame counter. Advances only on
//               the evaluate strobe; init reloads the start-of-game values.
//               Post-hit lives/death are exported so the parent can decide
//               life-pickup eligibility within the same evaluation.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module player_life_fsm
    import collision_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int INVULN_FRAMES = 60,
    parameter int LIVES_W       = 3,
    parameter int INV_W         = 7
) (
    input  wire logic               clk,
    input  wire logic               resetN,
    input  wire logic               init,
    input  wire logic               initDead,
    input  wire logic               evaluate,
    input  wire logic               hit,
    input  wire logic               gain,
    output logic [LIVES_W-1:0]      lives,
    output logic [LIVES_W-1:0]      livesAfterHit,
    output logic                    isDead,
    output logic                    deadAfterHit,
    output logic                    invuln,
    output logic                    charHit,
    output logic                    lifeGain
);

    player_state_t      r_state,    w_stateNext;
    logic [LIVES_W-1:0] r_lives,    w_livesNext;
    logic [INV_W-1:0]   r_inv,      w_invNext;
    logic               r_charHit,  w_charHitNext;
    logic               r_lifeGain, w_lifeGainNext;
    logic               w_hitTaken;

    // State, counters and one-cycle event pulses
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= P_ALIVE;
            r_lives    <= LIVES_W'(INIT_LIVES);
            r_inv      <= '0;
            r_charHit  <= 1'b0;
            r_lifeGain <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_lives    <= w_livesNext;
            r_inv      <= w_invNext;
            r_charHit  <= w_charHitNext;
            r_lifeGain <= w_lifeGainNext;
        end
    end

    // Next-state: hit is resolved before the life pickup is applied
    always_comb begin
        w_stateNext    = r_state;
        w_livesNext    = r_lives;
        w_invNext      = r_inv;
        w_charHitNext  = 1'b0;
        w_lifeGainNext = 1'b0;

        // Only a vulnerable player can be hit; an ALIVE player always has lives >= 1
        w_hitTaken    = hit && (r_state == P_ALIVE);
        livesAfterHit = w_hitTaken ? (r_lives - LIVES_W'(1)) : r_lives;
        deadAfterHit  = (r_state == P_DEAD) || (w_hitTaken && (r_lives == LIVES_W'(1)));

        if (init) begin
            w_stateNext = initDead ? P_DEAD : P_ALIVE;
            w_livesNext = initDead ? '0 : LIVES_W'(INIT_LIVES);
            w_invNext   = '0;
        end else if (evaluate) begin
            case (r_state)
                P_ALIVE: begin
                    if (hit) begin
                        w_charHitNext = 1'b1;
                        if (r_lives == LIVES_W'(1)) begin
                            w_stateNext = P_DEAD;
                        end else begin
                            w_stateNext = P_INVULN;
                            w_invNext   = INV_W'(INVULN_FRAMES);
                        end
                    end
                end
                P_INVULN: begin
                    w_invNext = r_inv - INV_W'(1);
                    if (r_inv == INV_W'(1)) begin
                        w_stateNext = P_ALIVE;
                    end
                end
                default: begin
                end
            endcase

            w_livesNext = livesAfterHit;
            if (gain && !deadAfterHit) begin
                w_lifeGainNext = 1'b1;
                w_livesNext    = (livesAfterHit >= LIVES_W'(MAX_LIVES))
                               ? LIVES_W'(MAX_LIVES)
                               : (livesAfterHit + LIVES_W'(1));
            end
        end
    end

    assign lives    = r_lives;
    assign isDead   = (r_state == P_DEAD);
    assign invuln   = (r_state == P_INVULN);
    assign charHit  = r_charHit;
    assign lifeGain = r_lifeGain;

endmodule

`default_nettype wire

// File: rtl/collision_event_ctrl.sv
//==============================================================================
// Module      : collision_event_ctrl
// Description : Frame-rate game-event controller. Latches per-pixel collision
//               pulses into sticky per-frame flags, evaluates them once per
//               frame, sequences both players' lives and arbitrates the single
//               bubble pop allowed per frame between the two arrows.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module collision_event_ctrl
    import collision_pkg::*;
#(
    parameter int INIT_LIVES    = 3,
    parameter int MAX_LIVES     = 5,
    parameter int INVULN_FRAMES = 60,
    parameter int LIVES_W       = 3,
    parameter int INV_W         = 7
) (
    input  wire logic              clk,
    input  wire logic              resetN,
    collision_event_ctrl_if.slave  bus
);

    logic               r_flagHit1, r_flagHit2, r_flagArrow1, r_flagArrow2, r_flagLife;
    logic               r_twoPlayer;
    logic               r_rrLast;       // 1 = player 2 credited last
    logic               r_popBubble, r_arrowClear1, r_arrowClear2;
    logic [1:0]         r_popCredit;

    logic               w_evaluate;
    logic               w_grant1, w_grant2;
    logic               w_arrowOk1, w_arrowOk2;
    logic               w_popNext, w_clr1Next, w_clr2Next, w_rrNext;
    logic [1:0]         w_creditNext;
    logic               w_isDead1, w_isDead2, w_deadAfter1, w_deadAfter2;
    logic [LIVES_W-1:0] w_livesAfter1, w_livesAfter2;

    // newGame pre-empts a coincident startOfFrame: that frame is dropped
    assign w_evaluate = bus.startOfFrame && !bus.newGame;

    // Sticky flags: at startOfFrame the old frame is consumed and the current
    // input seeds the new frame; otherwise inputs accumulate
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_flagHit1   <= 1'b0;
            r_flagHit2   <= 1'b0;
            r_flagArrow1 <= 1'b0;
            r_flagArrow2 <= 1'b0;
            r_flagLife   <= 1'b0;
        end else if (bus.newGame) begin
            r_flagHit1   <= 1'b0;
            r_flagHit2   <= 1'b0;
            r_flagArrow1 <= 1'b0;
            r_flagArrow2 <= 1'b0;
            r_flagLife   <= 1'b0;
        end else if (bus.startOfFrame) begin
            r_flagHit1   <= bus.bubbleHitChar_1;
            r_flagHit2   <= bus.bubbleHitChar_2;
            r_flagArrow1 <= bus.arrow_1_HitBubble;
            r_flagArrow2 <= bus.arrow_2_HitBubble;
            r_flagLife   <= bus.lifeHitChar;
        end else begin
            r_flagHit1   <= r_flagHit1   | bus.bubbleHitChar_1;
            r_flagHit2   <= r_flagHit2   | bus.bubbleHitChar_2;
            r_flagArrow1 <= r_flagArrow1 | bus.arrow_1_HitBubble;
            r_flagArrow2 <= r_flagArrow2 | bus.arrow_2_HitBubble;
            r_flagLife   <= r_flagLife   | bus.lifeHitChar;
        end
    end

    // Life token goes to the surviving player with fewer lives, tie to player 1
    always_comb begin
        w_grant1 = 1'b0;
        w_grant2 = 1'b0;
        if (r_flagLife) begin
            if (!w_deadAfter1 && !w_deadAfter2) begin
                if (w_livesAfter1 <= w_livesAfter2) w_grant1 = 1'b1;
                else                                w_grant2 = 1'b1;
            end else if (!w_deadAfter1) begin
                w_grant1 = 1'b1;
            end else if (!w_deadAfter2) begin
                w_grant2 = 1'b1;
            end
        end
    end

    // Single pop per frame; a contested pop alternates credit round-robin
    always_comb begin
        w_arrowOk1   = r_flagArrow1 && !w_isDead1;
        w_arrowOk2   = r_flagArrow2 && !w_isDead2;
        w_popNext    = 1'b0;
        w_creditNext = 2'b00;
        w_clr1Next   = 1'b0;
        w_clr2Next   = 1'b0;
        w_rrNext     = r_rrLast;
        if (w_evaluate) begin
            if (w_arrowOk1 && w_arrowOk2) begin
                w_popNext    = 1'b1;
                w_clr1Next   = 1'b1;
                w_clr2Next   = 1'b1;
                w_creditNext = r_rrLast ? CREDIT_P1 : CREDIT_P2;
                w_rrNext     = !r_rrLast;
            end else if (w_arrowOk1) begin
                w_popNext    = 1'b1;
                w_clr1Next   = 1'b1;
                w_creditNext = CREDIT_P1;
            end else if (w_arrowOk2) begin
                w_popNext    = 1'b1;
                w_clr2Next   = 1'b1;
                w_creditNext = CREDIT_P2;
            end
        end
    end

    // Pop pulses, round-robin pointer and latched player-count mode
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_popBubble   <= 1'b0;
            r_popCredit   <= 2'b00;
            r_arrowClear1 <= 1'b0;
            r_arrowClear2 <= 1'b0;
            r_rrLast      <= 1'b1;
            r_twoPlayer   <= 1'b1;
        end else if (bus.newGame) begin
            r_popBubble   <= 1'b0;
            r_popCredit   <= 2'b00;
            r_arrowClear1 <= 1'b0;
            r_arrowClear2 <= 1'b0;
            r_rrLast      <= 1'b1;
            r_twoPlayer   <= bus.twoPlayer;
        end else begin
            r_popBubble   <= w_popNext;
            r_popCredit   <= w_creditNext;
            r_arrowClear1 <= w_clr1Next;
            r_arrowClear2 <= w_clr2Next;
            r_rrLast      <= w_rrNext;
        end
    end

    player_life_fsm #(
        .INIT_LIVES(INIT_LIVES), .MAX_LIVES(MAX_LIVES), .INVULN_FRAMES(INVULN_FRAMES),
        .LIVES_W(LIVES_W), .INV_W(INV_W)
    ) u_player1 (
        .clk(clk), .resetN(resetN), .init(bus.newGame), .initDead(1'b0),
        .evaluate(w_evaluate), .hit(r_flagHit1), .gain(w_grant1),
        .lives(bus.lives_1), .livesAfterHit(w_livesAfter1), .isDead(w_isDead1),
        .deadAfterHit(w_deadAfter1), .invuln(bus.invuln_1),
        .charHit(bus.charHit_1), .lifeGain(bus.lifeGain_1)
    );

    player_life_fsm #(
        .INIT_LIVES(INIT_LIVES), .MAX_LIVES(MAX_LIVES), .INVULN_FRAMES(INVULN_FRAMES),
        .LIVES_W(LIVES_W), .INV_W(INV_W)
    ) u_player2 (
        .clk(clk), .resetN(resetN), .init(bus.newGame), .initDead(!bus.twoPlayer),
        .evaluate(w_evaluate), .hit(r_flagHit2), .gain(w_grant2),
        .lives(bus.lives_2), .livesAfterHit(w_livesAfter2), .isDead(w_isDead2),
        .deadAfterHit(w_deadAfter2), .invuln(bus.invuln_2),
        .charHit(bus.charHit_2), .lifeGain(bus.lifeGain_2)
    );

    assign bus.popBubble    = r_popBubble;
    assign bus.popCredit    = r_popCredit;
    assign bus.arrowClear_1 = r_arrowClear1;
    assign bus.arrowClear_2 = r_arrowClear2;
    assign bus.gameOver     = w_isDead1 && (w_isDead2 || !r_twoPlayer);

endmodule

`default_nettype wire

// File: doc/collision_event_ctrl.md
Name: collision_event_ctrl

Overview:
- Frame-rate game-event controller downstream of the per-pixel collision detector.
- Collision flags pulse whenever overlapping objects draw on the same pixel, so one contact raises many pulses per frame. This block latches them as sticky per-frame flags and evaluates them once per frame at startOfFrame.
- Per player, it sequences lives, invulnerability and death, and arbitrates the single bubble-pop permitted per frame between the two arrows.
- Outputs feed the bubble, arrow, character and score/HUD logic.

Parameters:
INIT_LIVES, 3, lives loaded at reset/newGame
MAX_LIVES, 5, saturation ceiling for life pickups
INVULN_FRAMES, 60, frames of invulnerability after a hit (>=1)
LIVES_W, 3, width of lives counters (must hold MAX_LIVES)
INV_W, 7, width of invulnerability counter (must hold INVULN_FRAMES)

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
newGame  in  1  one-cycle pulse; reinitialises game state
twoPlayer  in  1  sampled only on newGame
bubbleHitChar_1  in  1  per-pixel bubble/char1 overlap
bubbleHitChar_2  in  1  per-pixel bubble/char2 overlap
arrow_1_HitBubble  in  1  per-pixel arrow1/bubble overlap
arrow_2_HitBubble  in  1  per-pixel arrow2/bubble overlap
lifeHitChar  in  1  per-pixel life-token/any-char overlap
popBubble  out  1  one-cycle pulse: split/pop the hit bubble
popCredit  out  2  one-hot scoring player, valid with popBubble
arrowClear_1  out  1  one-cycle pulse: retract arrow 1
arrowClear_2  out  1  one-cycle pulse: retract arrow 2
charHit_1  out  1  one-cycle pulse: player 1 lost a life
charHit_2  out  1  one-cycle pulse: player 2 lost a life
lifeGain_1  out  1  one-cycle pulse: player 1 collected life
lifeGain_2  out  1  one-cycle pulse: player 2 collected life
invuln_1  out  1  level: player 1 invulnerable (blink)
invuln_2  out  1  level: player 2 invulnerable
lives_1  out  LIVES_W  player 1 lives
lives_2  out  LIVES_W  player 2 lives
gameOver  out  1  level: all active players dead

Behaviour:
- Reset (resetN=0, async):
  - all pulses and levels 0;
  - lives_1 = lives_2 = INIT_LIVES;
  - both players ALIVE; inv counters 0; sticky flags 0; rrLast = player 2 (so the first contested pop credits player 1).
- Sticky flags: five flags, each set on any cycle its input is 1 and startOfFrame=0.
  - On startOfFrame cycle T, the flags are evaluated, then cleared.
  - An input high exactly at T is stored into the new frame's flags, not evaluated at T.
- Latency: all evaluation results (pulses and updated levels/counters) appear at T+1. Pulses last exactly one cycle.
- Per-player FSM {ALIVE, INVULN, DEAD}, evaluated only at T:
  - ALIVE + hit flag: lives -= 1; charHit pulse. If the new lives value is 0, go DEAD; else go INVULN with inv = INVULN_FRAMES.
  - INVULN: hit flags ignored; inv -= 1. If inv was 1, go ALIVE. invuln output = (state==INVULN).
  - DEAD: hit, arrow and life flags ignored; stays DEAD until reset/newGame.
- Life pickup, when the lifeHitChar flag is set:
  - granted to exactly one non-DEAD player: the one with fewer lives; tie -> player 1.
  - lives += 1, saturating at MAX_LIVES. The lifeGain pulse fires even when saturated.
  - Hit and pickup in the same frame: the hit is processed first; a player the hit makes DEAD is not eligible.
- Pop arbitration: only arrow flags from non-DEAD players count.
  - One eligible flag: popBubble=1, popCredit = that player, arrowClear for that arrow.
  - Both eligible: popBubble=1 (single pop); both arrowClear pulses; credit to the player != rrLast; rrLast updated to the credited player.
  - Neither eligible: nothing.
- gameOver = DEAD_1 && (DEAD_2 || !twoPlayerReg).
- newGame (synchronous):
  - same as reset, except twoPlayerReg <= twoPlayer;
  - if twoPlayer=0: player 2 DEAD, lives_2 = 0.
  - newGame takes priority over a coincident startOfFrame; flags are cleared and that frame is not evaluated.
- twoPlayerReg resets to 1.
- Async reset mid-frame discards all pending flags.

Decomposition:
- Package collision_pkg: typedef enum player_state_t {P_ALIVE, P_INVULN, P_DEAD}; localparams for the one-hot popCredit codes (CREDIT_P1=2'b01, CREDIT_P2=2'b10).
- Sub-module player_life_fsm (instantiated twice). It owns state, the lives counter and the inv counter, and takes evaluate/hit/gain/init strobes.
- The top level owns the sticky flags, life-grant choice, pop arbitration and rrLast.

Test Plan:
- Hit pulses asserted for 200 cycles within one frame -> at the next startOfFrame+1, exactly one charHit_1 pulse; lives_1 3->2; invuln_1=1.
- After the hit, continuous overlap for 60 frames -> no charHit_1; invuln_1 falls at evaluation of frame 60 after the hit (INVULN_FRAMES=60); the next hit decrements lives_1 to 1.
- Both arrow flags set in frames 1, 2, 3 -> one popBubble per frame; popCredit = 01, 10, 01; both arrowClear pulses every frame.
- lifeHitChar with lives_1=2, lives_2=4 -> lifeGain_2=0, lifeGain_1=1, lives_1=3. With lives_1=5, lives_2=5 -> lifeGain_1=1, lives_1 stays 5.
- newGame with twoPlayer=0; three hits on player 1 across frames separated by more than 60 frames -> lives_1 3->2->1->0; gameOver=1 at T+1 of the third hit; later arrow_1 flags -> no popBubble.
- Hit asserted only in the startOfFrame cycle -> no charHit at T+1; charHit at the following frame's T+1. resetN low mid-frame with flags set -> no pulses after release.
